debounce_bank: RTL

Multi-channel debouncer for the front-panel push-buttons used to set the DS1302 clock. Each channel has:
- an input synchroniser
- a stability counter
- one-cycle rise and fall strobes
- an optional auto-repeat "press" strobe for held buttons

It sits between the raw pins and the UI/setting state machine, and generalises the single-channel debouncer.

---
 rtl/debounce_bank.sv | 122 ++++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// Multi-channel push-button debouncer: per-channel synchroniser, stability
// counter, rise/fall strobes and an optional auto-repeat press strobe.
module debounce_bank #(
    parameter int CHANNELS    = 4,
    parameter int FDIV_N      = 10,
    parameter int SYNC_STAGES = 2,
    parameter int REPEAT_N    = 8
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                ena,
    input  logic [CHANNELS-1:0] rpt_en,
    input  logic [CHANNELS-1:0] in_state,
    output logic [CHANNELS-1:0] out_state,
    output logic [CHANNELS-1:0] out_rise,
    output logic [CHANNELS-1:0] out_fall,
    output logic [CHANNELS-1:0] out_press,
    output logic                any_press
);

    logic [CHANNELS-1:0] press_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_p0;
        logic [FDIV_N-1:0]      cnt_p1;
        logic                   state_p1;
        logic                   rise_p1;
        logic                   fall_p1;
        logic [REPEAT_N-1:0]    rc_p1;
        logic                   armed_p1;
        logic                   s;
        logic                   mismatch;
        logic                   accept;
        logic                   rpt_clear;
        logic                   rpt_fire;

        // Stage 0: synchroniser, shifts every clock regardless of ena
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                sync_p0 <= '0;
            end else begin
                sync_p0 <= {sync_p0[SYNC_STAGES-2:0], in_state[i]};
            end
        end

        assign s         = sync_p0[SYNC_STAGES-1];
        assign mismatch  = (s != state_p1);
        assign accept    = mismatch && ena && (cnt_p1 == '1);
        // Acceptance in either direction restarts the repeat timing; a fall also
        // kills any repeat that would otherwise land on the same edge.
        assign rpt_clear = !state_p1 || !rpt_en[i] || accept;

        always_comb begin
            rpt_fire = 1'b0;
            if (!rpt_clear && ena) begin
                if (!armed_p1) begin
                    rpt_fire = (rc_p1 == '1);
                end else begin
                    rpt_fire = (rc_p1[REPEAT_N-2:0] == '1);
                end
            end
        end

        assign press_d[i] = (accept && s) || rpt_fire;

        // Stage 1: stability counter and accepted level with edge strobes
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                cnt_p1   <= '0;
                state_p1 <= 1'b0;
                rise_p1  <= 1'b0;
                fall_p1  <= 1'b0;
            end else begin
                rise_p1 <= 1'b0;
                fall_p1 <= 1'b0;
                if (!mismatch) begin
                    cnt_p1 <= '0;
                end else if (ena) begin
                    if (cnt_p1 == '1) begin
                        state_p1 <= s;
                        cnt_p1   <= '0;
                        rise_p1  <= s;
                        fall_p1  <= !s;
                    end else begin
                        cnt_p1 <= cnt_p1 + 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                rc_p1    <= '0;
                armed_p1 <= 1'b0;
            end else if (rpt_clear) begin
                rc_p1    <= '0;
                armed_p1 <= 1'b0;
            end else if (ena) begin
                rc_p1 <= rc_p1 + 1'b1;
                if (rpt_fire) begin
                    armed_p1 <= 1'b1;
                end
            end
        end

        assign out_state[i] = state_p1;
        assign out_rise[i]  = rise_p1;
        assign out_fall[i]  = fall_p1;
    end

    // Stage 2: registered press strobes, aligned with out_rise
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            out_press <= '0;
            any_press <= 1'b0;
        end else begin
            out_press <= press_d;
            any_press <= |press_d;
        end
    end

endmodule
